// File: rtl/asi_burst_agen_if.sv
// Command and beat-descriptor channels of the ASI burst address generator.
// The generator sits on the slave modport; the command source and descriptor consumer use the master modport.
interface asi_burst_agen_if #(
    parameter int unsigned AXI_DW     = 128,
    parameter int unsigned AXI_AW     = 40,
    parameter int unsigned AXI_LW     = 8,
    parameter int unsigned AXI_SW     = 3,
    parameter int unsigned AXI_BURSTW = 2
);
    localparam int unsigned NB = AXI_DW / 8;
    localparam int unsigned OW = $clog2(NB);
    localparam int unsigned BW = $clog2(NB + 1);

    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [AXI_AW-1:0]     cmd_addr;
    logic [AXI_LW-1:0]     cmd_len;
    logic [AXI_SW-1:0]     cmd_size;
    logic [AXI_BURSTW-1:0] cmd_burst;

    logic                  beat_valid;
    logic                  beat_ready;
    logic [AXI_AW-1:0]     beat_addr;
    logic [OW-1:0]         beat_lane;
    logic [BW-1:0]         beat_bytes;
    logic [NB-1:0]         beat_strb;
    logic [AXI_LW-1:0]     beat_idx;
    logic                  beat_last;
    logic                  beat_err;

    modport slave (
        input  cmd_valid, cmd_addr, cmd_len, cmd_size, cmd_burst, beat_ready,
        output cmd_ready, beat_valid, beat_addr, beat_lane, beat_bytes, beat_strb,
               beat_idx, beat_last, beat_err
    );

    modport master (
        output cmd_valid, cmd_addr, cmd_len, cmd_size, cmd_burst, beat_ready,
        input  cmd_ready, beat_valid, beat_addr, beat_lane, beat_bytes, beat_strb,
               beat_idx, beat_last, beat_err
    );
endinterface

// File: rtl/asi_burst_agen.sv
// AXI burst address generator: takes one AW/AR command and emits one descriptor per data beat
// (address, lane, byte count, strobe, index, last, error) for FIXED, INCR and WRAP bursts.
module asi_burst_agen #(
    parameter int unsigned AXI_DW     = 128,
    parameter int unsigned AXI_AW     = 40,
    parameter int unsigned AXI_LW     = 8,
    parameter int unsigned AXI_SW     = 3,
    parameter int unsigned AXI_BURSTW = 2
) (
    input  logic                   ACLK,
    input  logic                   ARESETn,
    asi_burst_agen_if.slave        io_bus
);
    localparam int unsigned NB  = AXI_DW / 8;
    localparam int unsigned OW  = $clog2(NB);
    localparam int unsigned BW  = $clog2(NB + 1);
    localparam int unsigned LW1 = AXI_LW + 1;
    localparam int unsigned KW  = AXI_LW + (1 << AXI_SW) + 1;

    localparam logic [AXI_BURSTW-1:0] BURST_FIXED = AXI_BURSTW'(0);
    localparam logic [AXI_BURSTW-1:0] BURST_INCR  = AXI_BURSTW'(1);
    localparam logic [AXI_BURSTW-1:0] BURST_WRAP  = AXI_BURSTW'(2);
    localparam logic [AXI_BURSTW-1:0] BURST_RSVD  = AXI_BURSTW'(3);

    typedef enum logic {ST_IDLE, ST_BURST} state_t;

    state_t                r_state;
    logic [AXI_AW-1:0]     r_addr;
    logic [OW-1:0]         r_lane;
    logic [BW-1:0]         r_bytes;
    logic [NB-1:0]         r_strb;
    logic [AXI_LW-1:0]     r_idx;
    logic [AXI_LW-1:0]     r_len;
    logic                  r_last;
    logic                  r_err;
    logic [AXI_BURSTW-1:0] r_burst;
    logic [AXI_AW-1:0]     r_step;
    logic [AXI_AW-1:0]     r_wrap_lo;
    logic [AXI_AW-1:0]     r_wrap_end;

    function automatic logic [NB-1:0] f_strb(input logic [BW-1:0] bytes, input logic [OW-1:0] lane);
        logic [2*NB-1:0] m;
        m = ((2*NB)'(1) << bytes) - (2*NB)'(1);
        m = m << lane;
        return m[NB-1:0];
    endfunction

    // Command decode, only consumed on the command handshake.
    logic [AXI_AW-1:0] w_c_s, w_c_smask, w_c_a0, w_c_w, w_c_wlo;
    logic [LW1-1:0]    w_c_beats;
    logic [KW-1:0]     w_c_span, w_c_end;
    logic [BW-1:0]     w_c_bytes0;
    logic              w_c_len_ok, w_c_err;

    assign w_c_s      = AXI_AW'(1) << io_bus.cmd_size;
    assign w_c_smask  = w_c_s - AXI_AW'(1);
    assign w_c_a0     = io_bus.cmd_addr & ~w_c_smask;
    assign w_c_beats  = LW1'(io_bus.cmd_len) + LW1'(1);
    assign w_c_span   = KW'(w_c_beats) << io_bus.cmd_size;
    assign w_c_end    = KW'(w_c_a0[11:0]) + w_c_span;
    assign w_c_w      = AXI_AW'(w_c_span);
    assign w_c_wlo    = io_bus.cmd_addr & ~(w_c_w - AXI_AW'(1));
    assign w_c_bytes0 = BW'(w_c_s - (io_bus.cmd_addr & w_c_smask));
    assign w_c_len_ok = io_bus.cmd_len inside {AXI_LW'(1), AXI_LW'(3), AXI_LW'(7), AXI_LW'(15)};

    assign w_c_err = (io_bus.cmd_burst == BURST_RSVD)
                   | (io_bus.cmd_size > AXI_SW'(OW))
                   | ((io_bus.cmd_burst == BURST_WRAP) & ~w_c_len_ok)
                   | ((io_bus.cmd_burst == BURST_WRAP) & ((io_bus.cmd_addr & w_c_smask) != '0))
                   | ((io_bus.cmd_burst == BURST_INCR) & (w_c_end > KW'(4096)));

    // Address of the following beat; INCR re-aligns so only beat 0 may be unaligned.
    logic [AXI_AW-1:0] w_wrap_sum, w_nxt_addr;
    logic [BW-1:0]     w_nxt_bytes;

    assign w_wrap_sum  = r_addr + r_step;
    assign w_nxt_addr  = (r_burst == BURST_WRAP)
                       ? ((w_wrap_sum == r_wrap_end) ? r_wrap_lo : w_wrap_sum)
                       : (r_addr & ~(r_step - AXI_AW'(1))) + r_step;
    assign w_nxt_bytes = BW'(r_step);

    logic w_beat_hs, w_cmd_hs;

    assign io_bus.beat_valid = (r_state == ST_BURST);
    assign w_beat_hs         = io_bus.beat_valid & io_bus.beat_ready;
    assign io_bus.cmd_ready  = (r_state == ST_IDLE) | (w_beat_hs & r_last);
    assign w_cmd_hs          = io_bus.cmd_valid & io_bus.cmd_ready;

    assign io_bus.beat_addr  = r_addr;
    assign io_bus.beat_lane  = r_lane;
    assign io_bus.beat_bytes = r_bytes;
    assign io_bus.beat_strb  = r_strb;
    assign io_bus.beat_idx   = r_idx;
    assign io_bus.beat_last  = r_last;
    assign io_bus.beat_err   = r_err;

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            r_state    <= ST_IDLE;
            r_addr     <= '0;
            r_lane     <= '0;
            r_bytes    <= '0;
            r_strb     <= '0;
            r_idx      <= '0;
            r_len      <= '0;
            r_last     <= 1'b0;
            r_err      <= 1'b0;
            r_burst    <= '0;
            r_step     <= '0;
            r_wrap_lo  <= '0;
            r_wrap_end <= '0;
        end else if (w_cmd_hs) begin
            r_state    <= ST_BURST;
            r_addr     <= io_bus.cmd_addr;
            r_lane     <= io_bus.cmd_addr[OW-1:0];
            r_bytes    <= w_c_err ? '0 : w_c_bytes0;
            r_strb     <= w_c_err ? '0 : f_strb(w_c_bytes0, io_bus.cmd_addr[OW-1:0]);
            r_idx      <= '0;
            r_len      <= io_bus.cmd_len;
            r_last     <= (io_bus.cmd_len == '0);
            r_err      <= w_c_err;
            r_burst    <= io_bus.cmd_burst;
            r_step     <= w_c_s;
            r_wrap_lo  <= w_c_wlo;
            r_wrap_end <= w_c_wlo + w_c_w;
        end else if (w_beat_hs) begin
            if (r_last) begin
                r_state <= ST_IDLE;
            end else begin
                r_idx  <= r_idx + AXI_LW'(1);
                r_last <= ((r_idx + AXI_LW'(1)) == r_len);
                // Errored and FIXED bursts hold beat 0's descriptor.
                if (!r_err && (r_burst != BURST_FIXED)) begin
                    r_addr  <= w_nxt_addr;
                    r_lane  <= w_nxt_addr[OW-1:0];
                    r_bytes <= w_nxt_bytes;
                    r_strb  <= f_strb(w_nxt_bytes, w_nxt_addr[OW-1:0]);
                end
            end
        end
    end
endmodule

// File: tb/tb_asi_burst_agen.sv
// Self-checking bench for asi_burst_agen: table of directed bursts, model-driven random bursts under
// backpressure, back-to-back command and mid-burst reset sequences, all through one beat scoreboard.
module tb_asi_burst_agen;
    logic ACLK = 1'b0;
    logic ARESETn;
    always #5 ACLK = ~ACLK;

    asi_burst_agen_if #(.AXI_DW(128), .AXI_AW(40), .AXI_LW(8), .AXI_SW(3), .AXI_BURSTW(2)) bus ();

    asi_burst_agen #(.AXI_DW(128), .AXI_AW(40), .AXI_LW(8), .AXI_SW(3), .AXI_BURSTW(2)) dut (
        .ACLK    (ACLK),
        .ARESETn (ARESETn),
        .io_bus  (bus)
    );

    typedef struct {
        logic [39:0] addr;
        int          bytes;
        logic [15:0] strb;
        int          idx;
        bit          last;
        bit          err;
    } exp_t;

    typedef struct {
        bit          first;
        logic [39:0] c_addr;
        int          c_len;
        int          c_size;
        int          c_burst;
        logic [39:0] e_addr;
        int          e_bytes;
        logic [15:0] e_strb;
        bit          e_err;
    } vec_t;

    exp_t exp_q[$];
    vec_t tv[$];
    int   n_chk  = 0;
    int   n_pass = 0;
    bit   rnd_en = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    endtask

    function automatic logic [15:0] mk_strb(input int bytes, input logic [3:0] lane);
        logic [31:0] m;
        m = ((32'd1 << bytes) - 32'd1) << lane;
        return m[15:0];
    endfunction

    function automatic vec_t mkv(input bit first, input logic [39:0] ca, input int cl, input int cs,
                                 input int cb, input logic [39:0] ea, input int eb,
                                 input logic [15:0] es, input bit ee);
        vec_t v;
        v.first = first; v.c_addr = ca; v.c_len = cl; v.c_size = cs; v.c_burst = cb;
        v.e_addr = ea; v.e_bytes = eb; v.e_strb = es; v.e_err = ee;
        return v;
    endfunction

    // Reference beats straight from the burst definitions (INCR via A0 + k*S).
    task automatic push_model(input logic [39:0] a, input int len, input int size, input int burst);
        logic [39:0] s, a0, w, lo, cur;
        bit          err;
        exp_t        e;
        s   = 40'd1 << size;
        a0  = a & ~(s - 40'd1);
        w   = 40'(len + 1) * s;
        lo  = a & ~(w - 40'd1);
        err = (burst == 3) || (size > 4)
           || (burst == 2 && !(len == 1 || len == 3 || len == 7 || len == 15))
           || (burst == 2 && (a % s) != 0)
           || (burst == 1 && (int'(a0[11:0]) + int'(w)) > 4096);
        cur = a;
        for (int k = 0; k <= len; k++) begin
            if (k > 0) begin
                if (burst == 1) cur = a0 + 40'(k) * s;
                else if (burst == 2) begin
                    cur = cur + s;
                    if (cur == lo + w) cur = lo;
                end
            end
            if (err) begin
                e.addr = a; e.bytes = 0;
            end else begin
                e.addr  = cur;
                e.bytes = (k == 0 || burst == 0) ? int'(s - (a % s)) : int'(s);
            end
            e.strb = err ? 16'h0 : mk_strb(e.bytes, e.addr[3:0]);
            e.idx = k; e.last = (k == len); e.err = err;
            exp_q.push_back(e);
        end
    endtask

    // Called just after a rising edge; returns just after the accepting edge with cmd_valid dropped.
    task automatic send_cmd(input logic [39:0] a, input int len, input int size, input int burst,
                            output bit was_last);
        bit ok = 1'b0;
        was_last = 1'b0;
        bus.cmd_valid = 1'b1;
        bus.cmd_addr  = a;
        bus.cmd_len   = 8'(len);
        bus.cmd_size  = 3'(size);
        bus.cmd_burst = 2'(burst);
        for (int i = 0; i < 400 && !ok; i++) begin
            @(negedge ACLK);
            ok       = bus.cmd_ready;
            was_last = bus.beat_valid & bus.beat_ready & bus.beat_last;
            @(posedge ACLK);
        end
        if (!ok) chk("cmd_accept_timeout", 64'(ok), 64'd1);
        #1;
        bus.cmd_valid = 1'b0;
    endtask

    task automatic drain();
        for (int n = 0; n < 600 && (exp_q.size() != 0 || bus.beat_valid); n++) begin
            @(posedge ACLK);
            #1;
        end
        chk("drain_pending", 64'(exp_q.size()), 64'd0);
        chk("drain_valid", 64'(bus.beat_valid), 64'd0);
    endtask

    // Pops the scoreboard on every beat handshake; checks hold-while-stalled.
    task automatic mon();
        exp_t        e;
        bit          stalled = 1'b0;
        logic [63:0] snap;
        forever begin
            @(negedge ACLK);
            if (ARESETn && bus.beat_valid) begin
                if (stalled)
                    chk("stall_stable", {bus.beat_addr, bus.beat_strb, bus.beat_idx},
                        snap);
                if (!bus.beat_ready) chk("cmd_ready_in_stall", 64'(bus.cmd_ready), 64'd0);
                else if (exp_q.size() == 0) chk("unexpected_beat", 64'(bus.beat_idx), 64'hFFFF);
                else begin
                    e = exp_q.pop_front();
                    chk($sformatf("addr[%0d]", e.idx),  64'(bus.beat_addr),  64'(e.addr));
                    chk($sformatf("lane[%0d]", e.idx),  64'(bus.beat_lane),  64'(e.addr[3:0]));
                    chk($sformatf("bytes[%0d]", e.idx), 64'(bus.beat_bytes), 64'(e.bytes));
                    chk($sformatf("strb[%0d]", e.idx),  64'(bus.beat_strb),  64'(e.strb));
                    chk($sformatf("idx[%0d]", e.idx),   64'(bus.beat_idx),   64'(e.idx));
                    chk($sformatf("last[%0d]", e.idx),  64'(bus.beat_last),  64'(e.last));
                    chk($sformatf("err[%0d]", e.idx),   64'(bus.beat_err),   64'(e.err));
                end
            end
            stalled = ARESETn && bus.beat_valid && !bus.beat_ready;
            snap    = {bus.beat_addr, bus.beat_strb, bus.beat_idx};
        end
    endtask

    initial begin
        exp_t e;
        bit   wl;
        ARESETn = 1'b0;
        bus.cmd_valid = 1'b0; bus.cmd_addr = '0; bus.cmd_len = '0; bus.cmd_size = '0; bus.cmd_burst = '0;
        bus.beat_ready = 1'b0;

        fork
            mon();
            forever begin
                @(posedge ACLK);
                #1;
                if (rnd_en) bus.beat_ready = ($urandom_range(0, 9) < 6);
            end
            begin
                #400000;
                $display("FAIL watchdog: run did not complete");
                $fatal(1);
            end
        join_none

        // Directed table: {first, cmd addr/len/size/burst, expected addr/bytes/strb/err}.
        tv.push_back(mkv(1, 40'h1004, 3, 2, 1, 40'h1004, 4, 16'h00F0, 0));
        tv.push_back(mkv(0, 0, 0, 0, 0,        40'h1008, 4, 16'h0F00, 0));
        tv.push_back(mkv(0, 0, 0, 0, 0,        40'h100C, 4, 16'hF000, 0));
        tv.push_back(mkv(0, 0, 0, 0, 0,        40'h1010, 4, 16'h000F, 0));
        tv.push_back(mkv(1, 40'h38, 3, 3, 2,   40'h38, 8, 16'hFF00, 0));
        tv.push_back(mkv(0, 0, 0, 0, 0,        40'h20, 8, 16'h00FF, 0));
        tv.push_back(mkv(0, 0, 0, 0, 0,        40'h28, 8, 16'hFF00, 0));
        tv.push_back(mkv(0, 0, 0, 0, 0,        40'h30, 8, 16'h00FF, 0));
        tv.push_back(mkv(1, 40'h003, 1, 4, 1,  40'h003, 13, 16'hFFF8, 0));
        tv.push_back(mkv(0, 0, 0, 0, 0,        40'h010, 16, 16'hFFFF, 0));
        tv.push_back(mkv(1, 40'h40, 2, 4, 0,   40'h40, 16, 16'hFFFF, 0));
        tv.push_back(mkv(0, 0, 0, 0, 0,        40'h40, 16, 16'hFFFF, 0));
        tv.push_back(mkv(0, 0, 0, 0, 0,        40'h40, 16, 16'hFFFF, 0));
        tv.push_back(mkv(1, 40'h100, 1, 2, 3,  40'h100, 0, 16'h0, 1));
        tv.push_back(mkv(0, 0, 0, 0, 0,        40'h100, 0, 16'h0, 1));
        tv.push_back(mkv(1, 40'hFF0, 1, 4, 1,  40'hFF0, 0, 16'h0, 1));
        tv.push_back(mkv(0, 0, 0, 0, 0,        40'hFF0, 0, 16'h0, 1));
        tv.push_back(mkv(1, 40'h40, 2, 2, 2,   40'h40, 0, 16'h0, 1));
        tv.push_back(mkv(0, 0, 0, 0, 0,        40'h40, 0, 16'h0, 1));
        tv.push_back(mkv(0, 0, 0, 0, 0,        40'h40, 0, 16'h0, 1));
        tv.push_back(mkv(1, 40'hFE0, 1, 4, 1,  40'hFE0, 16, 16'hFFFF, 0));
        tv.push_back(mkv(0, 0, 0, 0, 0,        40'hFF0, 16, 16'hFFFF, 0));
        tv.push_back(mkv(1, 40'h7, 0, 0, 1,    40'h7, 1, 16'h0080, 0));
        tv.push_back(mkv(1, 40'h0, 0, 5, 1,    40'h0, 0, 16'h0, 1));
        tv.push_back(mkv(1, 40'h3C, 1, 3, 2,   40'h3C, 0, 16'h0, 1));
        tv.push_back(mkv(0, 0, 0, 0, 0,        40'h3C, 0, 16'h0, 1));
        tv.push_back(mkv(1, 40'h1C, 1, 2, 2,   40'h1C, 4, 16'hF000, 0));
        tv.push_back(mkv(0, 0, 0, 0, 0,        40'h18, 4, 16'h0F00, 0));

        repeat (3) @(posedge ACLK);
        #1;
        chk("rst_cmd_ready",  64'(bus.cmd_ready),  64'd1);
        chk("rst_beat_valid", 64'(bus.beat_valid), 64'd0);
        chk("rst_addr",       64'(bus.beat_addr),  64'd0);
        chk("rst_lane",       64'(bus.beat_lane),  64'd0);
        chk("rst_bytes",      64'(bus.beat_bytes), 64'd0);
        chk("rst_strb",       64'(bus.beat_strb),  64'd0);
        chk("rst_idx",        64'(bus.beat_idx),   64'd0);
        chk("rst_last",       64'(bus.beat_last),  64'd0);
        chk("rst_err",        64'(bus.beat_err),   64'd0);
        ARESETn = 1'b1;
        bus.beat_ready = 1'b1;

        for (int i = 0; i < tv.size(); i++) begin
            if (tv[i].first) begin
                int j;
                j = i + 1;
                while (j < tv.size() && !tv[j].first) j++;
                for (int k = i; k < j; k++) begin
                    e.addr = tv[k].e_addr; e.bytes = tv[k].e_bytes; e.strb = tv[k].e_strb;
                    e.idx = k - i; e.last = (k == j - 1); e.err = tv[k].e_err;
                    exp_q.push_back(e);
                end
                send_cmd(tv[i].c_addr, tv[i].c_len, tv[i].c_size, tv[i].c_burst, wl);
            end
        end
        drain();

        // Random backpressure with model-predicted bursts.
        rnd_en = 1'b1;
        push_model(40'h1234, 5, 2, 1); send_cmd(40'h1234, 5, 2, 1, wl);
        push_model(40'h74, 7, 2, 2);   send_cmd(40'h74, 7, 2, 2, wl);
        push_model(40'h9, 3, 3, 0);    send_cmd(40'h9, 3, 3, 0, wl);
        push_model(40'h5, 9, 1, 1);    send_cmd(40'h5, 9, 1, 1, wl);
        for (int r = 0; r < 8; r++) begin
            logic [39:0] ra;
            int rl, rs, rb;
            ra = 40'($urandom_range(0, 4095));
            rl = $urandom_range(0, 7);
            rs = $urandom_range(0, 4);
            rb = $urandom_range(0, 2);
            push_model(ra, rl, rs, rb);
            send_cmd(ra, rl, rs, rb, wl);
        end
        drain();
        rnd_en = 1'b0;
        @(posedge ACLK);
        #1;
        bus.beat_ready = 1'b1;

        // Second command taken on the last beat handshake loads with no bubble.
        push_model(40'h100, 1, 4, 1); send_cmd(40'h100, 1, 4, 1, wl);
        push_model(40'h200, 0, 4, 1); send_cmd(40'h200, 0, 4, 1, wl);
        chk("b2b_on_last",    64'(wl),             64'd1);
        chk("b2b_valid",      64'(bus.beat_valid), 64'd1);
        chk("b2b_idx",        64'(bus.beat_idx),   64'd0);
        chk("b2b_addr",       64'(bus.beat_addr),  64'h200);
        drain();

        // Reset on beat 1 of a len-7 INCR aborts the rest of the burst.
        e.addr = 40'h2000; e.bytes = 4; e.strb = 16'h000F; e.idx = 0; e.last = 1'b0; e.err = 1'b0;
        exp_q.push_back(e);
        send_cmd(40'h2000, 7, 2, 1, wl);
        @(posedge ACLK);
        #1;
        chk("pre_rst_idx", 64'(bus.beat_idx), 64'd1);
        bus.beat_ready = 1'b0;
        ARESETn = 1'b0;
        @(posedge ACLK);
        #1;
        chk("midrst_valid",     64'(bus.beat_valid), 64'd0);
        chk("midrst_cmd_ready", 64'(bus.cmd_ready),  64'd1);
        chk("midrst_idx",       64'(bus.beat_idx),   64'd0);
        chk("midrst_addr",      64'(bus.beat_addr),  64'd0);
        chk("midrst_strb",      64'(bus.beat_strb),  64'd0);
        ARESETn = 1'b1;
        bus.beat_ready = 1'b1;
        push_model(40'h300, 1, 2, 1); send_cmd(40'h300, 1, 2, 1, wl);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
